raster_streamer: RTL and testbench
==================================

RASTER_STREAMER -- requirements
Module: raster_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, meaning active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 960, meaning active lines per frame.
REQ-003 SHALL have parameter DATA_W, default 12, meaning pixel width in bits.
REQ-004 SHALL have parameter HBLANK, default 16, meaning idle cycles inserted after each line; used only when the blanking feature is compiled in.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port start  input  1  single-cycle pulse that begins one frame.
REQ-008 SHALL have port src_data  input  DATA_W  upstream pixel value.
REQ-009 SHALL have port src_valid  input  1  upstream pixel available.
REQ-010 SHALL have port src_ready  output  1  pixel accepted this cycle when high together with src_valid.
REQ-011 SHALL have port data_out  output  DATA_W  pixel to the downstream filter.
REQ-012 SHALL have port x  output  11  column of data_out.
REQ-013 SHALL have port y  output  11  row of data_out.
REQ-014 SHALL have port read  output  1  data_out/x/y valid this cycle; the downstream write strobe.
REQ-015 SHALL have port busy  output  1  frame in progress.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-017 SHALL implement FSM states IDLE, ACTIVE, HBLANK, DONE.
REQ-018 SHALL leave IDLE for ACTIVE on start; the column and row counters SHALL load 0.
REQ-019 SHALL assert src_ready combinationally only in ACTIVE.
REQ-020 SHALL, on each accepted handshake (src_valid and src_ready both high), drive read=1 on the next cycle; data_out SHALL equal the accepted src_data, and x/y SHALL equal the counter values at acceptance.
REQ-021 SHALL hold read=0 in every cycle that does not follow an accepted handshake; data_out/x/y SHALL hold their last values.
REQ-022 SHALL, while src_valid stays high, accept one pixel per cycle; there is no downstream backpressure.
REQ-023 SHALL, when the accepted pixel has column WIDTH-1, wrap the column to 0 and increment the row.
REQ-024 SHALL, when the accepted pixel is (WIDTH-1, HEIGHT-1), go to DONE and drop src_ready the next cycle.
REQ-025 SHALL, in DONE, pulse frame_done for exactly one cycle (coincident with read for the last pixel) and then go to IDLE.
REQ-026 SHALL drive busy high in ACTIVE, HBLANK and DONE, and low in IDLE.
REQ-027 SHALL ignore start in any state other than IDLE.
REQ-028 SHALL, if start arrives in the same cycle that DONE returns to IDLE, ignore it; a new frame requires start while in IDLE.
REQ-029 SHALL use counter widths of 11 bits; WIDTH and HEIGHT SHALL not exceed 2047.

Reset
REQ-030 SHALL, on rst high, immediately move to IDLE, clear both counters, and force src_ready=0, read=0, busy=0, frame_done=0, data_out=0, x=0, y=0.
REQ-031 SHALL, on reset asserted mid-frame, discard the partial frame; the next frame SHALL start at (0,0) on the next start.

Configuration
REQ-032 SHALL use the macro RASTER_STREAMER_HBLANK_EN to control line blanking.
REQ-033 SHALL, when RASTER_STREAMER_HBLANK_EN is defined, enter HBLANK after accepting each pixel with column WIDTH-1 (except the last pixel of the frame), hold src_ready=0 for exactly HBLANK cycles, then return to ACTIVE.
REQ-034 SHALL, when RASTER_STREAMER_HBLANK_EN is undefined, make HBLANK unreachable, so that lines stream back-to-back with no gap.

Verification (WIDTH=4, HEIGHT=3, HBLANK=2)
REQ-035 SHALL cover: with the macro undefined, src_valid held high with src_data=1..12 and a start pulse -> read high for 12 consecutive cycles; (x,y) runs (0,0)..(3,0),(0,1)..(3,2); data_out runs 1..12; frame_done high only with the 12th pixel.
REQ-036 SHALL cover: with the macro defined and the same stimulus -> 2-cycle read=0 gaps after pixels 4 and 8, no gap after pixel 12, and 16 cycles total from the first read to frame_done.
REQ-037 SHALL cover: src_valid toggling 1,0,1,0 -> read follows the accepted cycles with 1-cycle lag, and x increments only on accepted pixels.
REQ-038 SHALL cover: start pulsed while busy at pixel 5 -> no effect, and the frame completes at pixel 12.
REQ-039 SHALL cover: rst asserted after pixel 6, then released, then start -> all outputs 0 during reset, and the first read after restart carries x=0, y=0.
REQ-040 SHALL cover: two frames issued back-to-back (start in IDLE right after frame_done) -> the second frame's first pixel is at (0,0), and exactly two frame_done pulses occur.

Source files
------------

// File: rtl/raster_streamer.sv
// raster_streamer: streams one WIDTH x HEIGHT frame of pixels from a valid/ready source, tagging each with (x, y).
// Define RASTER_STREAMER_HBLANK_EN to insert HBLANK idle cycles after every line but the last.
module raster_streamer #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 960,
  parameter int DATA_W = 12,
  parameter int HBLANK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [10:0]       x,
  output logic [10:0]       y,
  output logic              read,
  output logic              busy,
  output logic              frame_done
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_HBLANK = 2'd2, S_DONE = 2'd3;
`ifdef RASTER_STREAMER_HBLANK_EN
  localparam logic [1:0] S_EOL = S_HBLANK;
`else
  localparam logic [1:0] S_EOL = S_ACTIVE;
`endif
  logic [1:0]        r_state;
  logic [10:0]       r_col, r_row, r_x, r_y;
  logic [15:0]       r_hcnt;
  logic [DATA_W-1:0] r_data;
  logic              r_read;
  logic              w_acc, w_eol, w_eof;
  assign src_ready  = r_state == S_ACTIVE;
  assign w_acc      = src_valid & src_ready;
  assign w_eol      = r_col == 11'(WIDTH - 1);
  assign w_eof      = w_eol & (r_row == 11'(HEIGHT - 1));
  assign data_out   = r_data;
  assign x          = r_x;
  assign y          = r_y;
  assign read       = r_read;
  assign busy       = r_state != S_IDLE;
  assign frame_done = r_state == S_DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_hcnt  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_data  <= '0;
      r_read  <= 1'b0;
    end else begin
      r_read <= w_acc;
      if (w_acc) begin
        r_data  <= src_data;
        r_x     <= r_col;
        r_y     <= r_row;
        r_col   <= w_eol ? 11'd0 : r_col + 11'd1;
        r_row   <= w_eol ? r_row + 11'd1 : r_row;
        r_hcnt  <= '0;
        r_state <= w_eof ? S_DONE : w_eol ? S_EOL : S_ACTIVE;
      end else if (r_state == S_IDLE && start) begin
        r_col   <= '0;
        r_row   <= '0;
        r_state <= S_ACTIVE;
      end else if (r_state == S_HBLANK) begin
        r_hcnt  <= r_hcnt + 16'd1;
        r_state <= r_hcnt == 16'(HBLANK - 1) ? S_ACTIVE : S_HBLANK;
      end else if (r_state == S_DONE) begin
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_raster_streamer.sv
// tb_raster_streamer: randomized stimulus checked every cycle against a pixel-index reference model.
module tb_raster_streamer;
  localparam int W = 4, H = 3, HB = 2, DW = 12, N = W * H;
`ifdef RASTER_STREAMER_HBLANK_EN
  localparam bit HB_EN = 1'b1;
`else
  localparam bit HB_EN = 1'b0;
`endif
  logic          clk = 1'b0, rst, start, src_valid, src_ready, read, busy, frame_done;
  logic [DW-1:0] src_data, data_out;
  logic [10:0]   x, y;
  raster_streamer #(.WIDTH(W), .HEIGHT(H), .DATA_W(DW), .HBLANK(HB)) dut (
    .clk(clk), .rst(rst), .start(start), .src_data(src_data), .src_valid(src_valid),
    .src_ready(src_ready), .data_out(data_out), .x(x), .y(y), .read(read),
    .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0;
  int cyc = 0, first_rd = -1, fd_cyc = 0, fd_cnt = 0;
  bit m_busy = 0, m_done = 0;
  int m_pix = 0, m_gap = 0;
  logic          e_read = 0;
  logic [DW-1:0] e_data = '0;
  logic [10:0]   e_x = '0, e_y = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit m_ready();
    return m_busy && !m_done && m_gap == 0 && m_pix < N;
  endfunction
  task automatic step(input bit v, input bit s, input bit r, input logic [DW-1:0] d);
    bit acc, old_busy, old_done;
    @(negedge clk);
    chk("src_ready", 32'(src_ready), 32'(m_ready()));
    chk("read", 32'(read), 32'(e_read));
    chk("data_out", 32'(data_out), 32'(e_data));
    chk("x", 32'(x), 32'(e_x));
    chk("y", 32'(y), 32'(e_y));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    if (read === 1'b1 && first_rd < 0) first_rd = cyc;
    if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
    cyc++;
    src_valid = v; start = s; rst = r; src_data = d;
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_done = 0; m_pix = 0; m_gap = 0;
      e_read = 0; e_data = '0; e_x = '0; e_y = '0;
    end else begin
      acc = m_ready() && v;
      old_busy = m_busy;
      old_done = m_done;
      e_read = acc;
      if (acc) begin
        e_data = d;
        e_x = 11'(m_pix % W);
        e_y = 11'(m_pix / W);
        m_pix++;
        if (m_pix == N) m_done = 1;
        else if (HB_EN && m_pix % W == 0) m_gap = HB;
      end else if (m_gap > 0) m_gap--;
      if (old_done) begin m_done = 0; m_busy = 0; end
      if (!old_busy && s) begin m_busy = 1; m_pix = 0; m_gap = 0; end
    end
  endtask
  // vmode: 0 valid held, 1 toggling, 2 random; smode: 0 none, 1 at pixel 5, 2 random, 3 during DONE
  task automatic frame(input int vmode, input int smode);
    bit v, s;
    step(vmode == 0, 1'b1, 1'b0, DW'(1));
    for (int i = 0; i < 200 && m_busy; i++) begin
      v = vmode == 0 ? 1'b1 : vmode == 1 ? (i % 2 == 0) : ($urandom_range(3) != 0);
      s = smode == 1 ? (m_pix == 5) : smode == 2 ? ($urandom_range(3) == 0) : smode == 3 ? m_done : 1'b0;
      step(v, s, 1'b0, vmode == 0 ? DW'(m_pix + 1) : DW'($urandom));
    end
    if (m_busy) begin
      checks++; errors++;
      $display("FAIL frame_timeout got=busy exp=idle");
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; src_valid = 1'b0; src_data = '0;
    step(1'b1, 1'b1, 1'b1, '1);
    step(1'b1, 1'b1, 1'b1, '1);
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, DW'(7));
    first_rd = -1; fd_cnt = 0;
    frame(0, 0);
    chk("frame_span", 32'(fd_cyc - first_rd + 1), 32'(N + (HB_EN ? (H - 1) * HB : 0)));
    chk("fd_count1", 32'(fd_cnt), 32'd1);
    frame(1, 0);
    frame(0, 1);
    step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 50 && m_pix < 6; i++) step(1'b1, 1'b0, 1'b0, DW'(m_pix + 1));
    repeat (3) step(1'b1, 1'b1, 1'b1, DW'(9));
    step(1'b0, 1'b0, 1'b0, '0);
    frame(0, 0);
    fd_cnt = 0;
    frame(0, 3);
    frame(0, 0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("fd_count2", 32'(fd_cnt), 32'd2);
    repeat (4) frame(2, 2);
    step(1'b0, 1'b0, 1'b0, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
